systolic_ctrl: RTL

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer feeding a 3x3 systolic array with 3x3 byte matrices
module systolic_ctrl #(
    parameter int DRAIN_CYC = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [71:0]  i_a_mat,
    input  logic [71:0]  i_b_mat,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [143:0] o_c_mat,
    output logic         o_busy,
    output logic [7:0]   o_job_cnt,
    output logic         o_sa_rst_n,
    output logic [23:0]  o_sa_a,
    output logic [23:0]  o_sa_b,
    input  logic [143:0] i_sa_c
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [71:0] a_reg;
    logic [71:0] b_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            o_out_valid <= 1'b0;
            o_c_mat     <= '0;
            o_job_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_in_valid) begin
                        a_reg <= i_a_mat;
                        b_reg <= i_b_mat;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (cnt == 4'd2) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    // Array accumulators are final by the last drain cycle.
                    if (cnt == 4'(DRAIN_CYC - 1)) begin
                        cnt         <= '0;
                        o_c_mat     <= i_sa_c;
                        o_out_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        o_job_cnt   <= o_job_cnt + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_in_ready = i_rst_n && (state == IDLE);
    assign o_busy     = i_rst_n && (state != IDLE);
    assign o_sa_rst_n = i_rst_n && (state != CLEAR);

    // Beat k presents column k of A and row k of B.
    always_comb begin
        o_sa_a = '0;
        o_sa_b = '0;
        if (i_rst_n && state == FEED) begin
            for (int r = 0; r < 3; r++) begin
                o_sa_a[8*r +: 8] = a_reg[8*(3*r + int'(cnt[1:0])) +: 8];
                o_sa_b[8*r +: 8] = b_reg[8*(3*int'(cnt[1:0]) + r) +: 8];
            end
        end
    end

endmodule
